// File: rtl/sa_result_tx_framer_pkg.sv
// Shared definitions for the result TX framer: FSM encoding, header default, frame length.
package sa_result_tx_framer_pkg;

   localparam int unsigned ROW_DEF    = 9;
   localparam int unsigned W_RES_DEF  = 32;
   localparam int unsigned W_DATA_DEF = 8;
   localparam logic [7:0]  HDR_DEF    = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Header + payload bytes + checksum
   function automatic int unsigned nbytes(input int unsigned row, input int unsigned w_res);
      return row * w_res / 8 + 2;
   endfunction

endpackage

// File: rtl/sa_result_tx_framer_if.sv
// Result-vector handshake and UART TX byte link; master = framer side, slave = environment side.
interface sa_result_tx_framer_if
   import sa_result_tx_framer_pkg::*;
#(
   parameter int unsigned ROW    = ROW_DEF,
   parameter int unsigned W_RES  = W_RES_DEF,
   parameter int unsigned W_DATA = W_DATA_DEF
);
   logic                   i_res_valid;
   logic [ROW*W_RES-1:0]   i_res_data;
   logic                   o_res_ready;
   logic                   o_tx_dv;
   logic [W_DATA-1:0]      o_tx_byte;
   logic                   i_tx_active;
   logic                   i_tx_done;

   modport master (
      input  i_res_valid, i_res_data, i_tx_active, i_tx_done,
      output o_res_ready, o_tx_dv, o_tx_byte
   );

   modport slave (
      output i_res_valid, i_res_data, i_tx_active, i_tx_done,
      input  o_res_ready, o_tx_dv, o_tx_byte
   );
endinterface

// File: rtl/sa_result_byte_sel.sv
// Combinational frame byte mux: header, payload byte from the shadow vector, or checksum.
module sa_result_byte_sel
   import sa_result_tx_framer_pkg::*;
#(
   parameter int unsigned       ROW    = ROW_DEF,
   parameter int unsigned       W_RES  = W_RES_DEF,
   parameter int unsigned       W_DATA = W_DATA_DEF,
   parameter logic [W_DATA-1:0] HDR    = HDR_DEF,
   parameter int unsigned       NBYTES = nbytes(ROW, W_RES),
   parameter int unsigned       IDX_W  = $clog2(NBYTES)
) (
   input  logic [ROW*W_RES-1:0] i_shadow,
   input  logic [IDX_W-1:0]     i_idx,
   input  logic [W_DATA-1:0]    i_csum,
   output logic [W_DATA-1:0]    o_byte_c
);
   localparam int NPAY = int'(NBYTES) - 2;

   // Payload is the shadow vector read out byte by byte from bit 0 upward
   always_comb begin
      o_byte_c = '0;
      if (i_idx == '0) begin
         o_byte_c = HDR;
      end else if (i_idx == IDX_W'(NBYTES - 1)) begin
         o_byte_c = i_csum;
      end else begin
         for (int b = 0; b < NPAY; b++) begin
            if (i_idx == IDX_W'(b + 1)) o_byte_c = i_shadow[b*W_DATA +: W_DATA];
         end
      end
   end

endmodule

// File: rtl/sa_result_tx_framer.sv
// Captures one result vector and streams it to the UART TX as header/payload/checksum frame.
module sa_result_tx_framer
   import sa_result_tx_framer_pkg::*;
#(
   parameter int unsigned       ROW    = ROW_DEF,
   parameter int unsigned       W_RES  = W_RES_DEF,
   parameter int unsigned       W_DATA = W_DATA_DEF,
   parameter logic [W_DATA-1:0] HDR    = HDR_DEF
) (
   input  logic                  i_clk,
   input  logic                  rst_n,
   sa_result_tx_framer_if.master bus,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_overrun
);
   localparam int unsigned       NBYTES   = nbytes(ROW, W_RES);
   localparam int unsigned       IDX_W    = $clog2(NBYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [W_DATA-1:0]     r_csum;
   logic [ROW*W_RES-1:0]  r_shadow;
   logic                  r_tx_dv;
   logic [W_DATA-1:0]     r_tx_byte;
   logic                  r_busy;
   logic                  r_frame_done;
   logic                  r_overrun;
   logic                  r_res_ready;

   state_t                w_state_nxt;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [W_DATA-1:0]     w_csum_nxt;
   logic                  w_capture;
   logic                  w_tx_dv_nxt;
   logic [W_DATA-1:0]     w_tx_byte_nxt;
   logic                  w_overrun_nxt;
   logic [W_DATA-1:0]     w_sel_byte;

   sa_result_byte_sel #(
      .ROW    (ROW),
      .W_RES  (W_RES),
      .W_DATA (W_DATA),
      .HDR    (HDR),
      .NBYTES (NBYTES),
      .IDX_W  (IDX_W)
   ) u_byte_sel (
      .i_shadow (r_shadow),
      .i_idx    (r_idx),
      .i_csum   (r_csum),
      .o_byte_c (w_sel_byte)
   );

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_csum_nxt    = r_csum;
      w_capture     = 1'b0;
      w_tx_dv_nxt   = 1'b0;
      w_tx_byte_nxt = r_tx_byte;
      w_overrun_nxt = r_overrun;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.i_res_valid) begin
               w_capture   = 1'b1;
               w_idx_nxt   = '0;
               w_csum_nxt  = '0;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.i_tx_active) begin
               w_tx_dv_nxt   = 1'b1;
               w_tx_byte_nxt = w_sel_byte;
               w_state_nxt   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_tx_done) begin
               // Header and checksum bytes never contribute to the sum
               if ((r_idx != '0) && (r_idx != LAST_IDX)) w_csum_nxt = r_csum + r_tx_byte;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (bus.i_res_valid && (r_state != ST_IDLE)) w_overrun_nxt = 1'b1;
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_csum       <= '0;
         r_tx_dv      <= 1'b0;
         r_tx_byte    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
         r_res_ready  <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_csum       <= w_csum_nxt;
         r_tx_dv      <= w_tx_dv_nxt;
         r_tx_byte    <= w_tx_byte_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_frame_done <= (w_state_nxt == ST_DONE);
         r_overrun    <= w_overrun_nxt;
         r_res_ready  <= (w_state_nxt == ST_IDLE);
      end
   end

   // Shadow vector is pure datapath; only meaningful after a capture
   always_ff @(posedge i_clk) begin
      if (rst_n && w_capture) r_shadow <= bus.i_res_data;
   end

   assign bus.o_res_ready = r_res_ready;
   assign bus.o_tx_dv     = r_tx_dv;
   assign bus.o_tx_byte   = r_tx_byte;
   assign o_busy          = r_busy;
   assign o_frame_done    = r_frame_done;
   assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_sa_result_tx_framer.sv
// Randomized self-checking bench for sa_result_tx_framer with a UART TX model and frame reference model.
`timescale 1ns/1ps
module tb_sa_result_tx_framer;
   import sa_result_tx_framer_pkg::*;

   localparam int unsigned ROW    = 9;
   localparam int unsigned W_RES  = 32;
   localparam int unsigned W_DATA = 8;
   localparam int unsigned VW     = ROW * W_RES;
   localparam int unsigned NB     = ROW * W_RES / 8 + 2;
   localparam int          BUDGET = 3000;

   logic i_clk = 1'b0;
   logic rst_n;
   logic o_busy, o_frame_done, o_overrun;

   always #5 i_clk = ~i_clk;

   sa_result_tx_framer_if #(.ROW(ROW), .W_RES(W_RES), .W_DATA(W_DATA)) bus ();

   sa_result_tx_framer #(.ROW(ROW), .W_RES(W_RES), .W_DATA(W_DATA), .HDR(8'hA5)) u_dut (
      .i_clk        (i_clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_overrun    (o_overrun)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         tx_left = 0;
   int         tx_lat  = 10;
   logic       tx_busy = 1'b0;
   logic       tx_abandon = 1'b0;
   logic       force_active = 1'b0;
   logic [7:0] tx_cur = '0;
   int         dv_cnt = 0, fd_cnt = 0, unstable = 0, dv_active = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame: header, lanes low-to-high, each lane LSB byte first, then sum of payload mod 256
   function automatic void build_frame(input logic [VW-1:0] v);
      int sum = 0;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < int'(ROW); k++) begin
         logic [31:0] lane = 32'(v >> (k * 32));
         for (int j = 0; j < 4; j++) begin
            logic [7:0] b = 8'((lane >> (8 * j)) & 32'hFF);
            exp_q.push_back(b);
            sum += int'(b);
         end
      end
      exp_q.push_back(8'(sum % 256));
   endfunction

   // One cycle: observe at the falling edge, advance the UART TX model, drive its outputs
   task automatic step();
      logic done_m;
      @(negedge i_clk);
      done_m = 1'b0;
      if (o_frame_done) fd_cnt++;
      if (bus.o_tx_dv) begin
         dv_cnt++;
         if (bus.i_tx_active) dv_active++;
      end
      if (tx_left > 0) begin
         if (!tx_abandon && (bus.o_tx_byte !== tx_cur)) unstable++;
         tx_left--;
         if (tx_left == 0) begin
            done_m     = 1'b1;
            tx_busy    = 1'b0;
            tx_abandon = 1'b0;
         end
      end else if (bus.o_tx_dv) begin
         got_q.push_back(bus.o_tx_byte);
         tx_cur  = bus.o_tx_byte;
         tx_busy = 1'b1;
         tx_left = tx_lat;
      end
      bus.i_tx_active = tx_busy | force_active;
      bus.i_tx_done   = done_m;
   endtask

   task automatic send_vec(input logic [VW-1:0] v);
      bus.i_res_valid = 1'b1;
      bus.i_res_data  = v;
      step();
      bus.i_res_valid = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int c   = 0;
      int fd0 = fd_cnt;
      while (fd_cnt == fd0 && c < BUDGET) begin
         step();
         c++;
      end
      check_eq({tag, " frame_done seen"}, 32'(fd_cnt > fd0), 32'd1);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int c = 0;
      while (got_q.size() < n && c < BUDGET) begin
         step();
         c++;
      end
      check_eq({tag, " bytes reached"}, 32'(got_q.size() >= n), 32'd1);
   endtask

   task automatic cmp_frame(input string tag);
      check_eq({tag, " length"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq($sformatf("%s byte %0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check_eq({tag, " tx_byte stable"}, 32'(unstable), 32'd0);
      check_eq({tag, " dv while active"}, 32'(dv_active), 32'd0);
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v = '0;
      for (int k = 0; k < int'(ROW); k++) v = v | (VW'($urandom()) << (k * 32));
      return v;
   endfunction

   initial begin
      logic [VW-1:0] va, vb;
      int dv0, fd0;

      rst_n            = 1'b0;
      bus.i_res_valid  = 1'b0;
      bus.i_res_data   = '0;
      bus.i_tx_active  = 1'b0;
      bus.i_tx_done    = 1'b0;
      repeat (3) step();

      // Reset wins over a simultaneous valid
      bus.i_res_valid = 1'b1;
      bus.i_res_data  = rand_vec();
      step();
      bus.i_res_valid = 1'b0;
      rst_n = 1'b1;
      check_eq("rst ready", 32'(bus.o_res_ready), 32'd1);
      check_eq("rst dv", 32'(bus.o_tx_dv), 32'd0);
      check_eq("rst tx_byte", 32'(bus.o_tx_byte), 32'd0);
      check_eq("rst busy", 32'(o_busy), 32'd0);
      check_eq("rst frame_done", 32'(o_frame_done), 32'd0);
      check_eq("rst overrun", 32'(o_overrun), 32'd0);

      // Idle for 20 cycles, including a stale done pulse
      dv0 = dv_cnt;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 5) bus.i_tx_done = 1'b1;
      end
      check_eq("idle dv count", 32'(dv_cnt - dv0), 32'd0);
      check_eq("idle ready", 32'(bus.o_res_ready), 32'd1);
      check_eq("idle busy", 32'(o_busy), 32'd0);
      check_eq("idle overrun", 32'(o_overrun), 32'd0);

      // Directed frame: lane k = k+1, latency and frame_done behaviour
      va = '0;
      for (int k = 0; k < int'(ROW); k++) va = va | (VW'(k + 1) << (k * 32));
      build_frame(va);
      got_q.delete();
      tx_lat = 10;
      fd0 = fd_cnt;
      dv0 = dv_cnt;
      send_vec(va);
      check_eq("lat busy after capture", 32'(o_busy), 32'd1);
      check_eq("lat ready after capture", 32'(bus.o_res_ready), 32'd0);
      check_eq("lat no dv yet", 32'(bus.o_tx_dv), 32'd0);
      step();
      check_eq("lat first dv", 32'(dv_cnt - dv0), 32'd1);
      wait_frame("seq");
      check_eq("seq ready in DONE", 32'(bus.o_res_ready), 32'd0);
      step();
      check_eq("seq ready after DONE", 32'(bus.o_res_ready), 32'd1);
      check_eq("seq busy after DONE", 32'(o_busy), 32'd0);
      repeat (5) step();
      cmp_frame("seq");
      if (got_q.size() == NB) check_eq("seq checksum", 32'(got_q[NB-1]), 32'h2D);
      check_eq("seq frame_done count", 32'(fd_cnt - fd0), 32'd1);

      // Byte order within a lane
      va = '0;
      va[31:0] = 32'hDEADBEEF;
      build_frame(va);
      got_q.delete();
      tx_lat = 3;
      send_vec(va);
      wait_frame("order");
      step();
      cmp_frame("order");
      if (got_q.size() == NB) begin
         check_eq("order b1", 32'(got_q[1]), 32'hEF);
         check_eq("order b4", 32'(got_q[4]), 32'hDE);
         check_eq("order checksum", 32'(got_q[NB-1]), 32'h38);
      end

      // Random frames with random TX latency
      for (int t = 0; t < 3; t++) begin
         va = rand_vec();
         build_frame(va);
         got_q.delete();
         tx_lat = int'($urandom_range(1, 12));
         repeat ($urandom_range(0, 4)) step();
         send_vec(va);
         wait_frame($sformatf("rand%0d", t));
         step();
         cmp_frame($sformatf("rand%0d", t));
      end

      // Overrun during byte 5: dropped vector, sticky flag, no second frame
      check_eq("ovr before", 32'(o_overrun), 32'd0);
      va = rand_vec();
      vb = rand_vec();
      build_frame(va);
      got_q.delete();
      tx_lat = 6;
      send_vec(va);
      wait_bytes(6, "ovr");
      send_vec(vb);
      check_eq("ovr set", 32'(o_overrun), 32'd1);
      wait_frame("ovr");
      step();
      cmp_frame("ovr");
      dv0 = dv_cnt;
      repeat (40) step();
      check_eq("ovr no second frame", 32'(dv_cnt - dv0), 32'd0);
      check_eq("ovr sticky", 32'(o_overrun), 32'd1);
      check_eq("ovr idle busy", 32'(o_busy), 32'd0);

      // TX back-pressure at ISSUE with a stale done
      va = rand_vec();
      build_frame(va);
      got_q.delete();
      tx_lat = 4;
      force_active = 1'b1;
      step();
      send_vec(va);
      dv0 = dv_cnt;
      for (int i = 0; i < 50; i++) begin
         step();
         if (i == 20) bus.i_tx_done = 1'b1;
      end
      check_eq("bp no dv", 32'(dv_cnt - dv0), 32'd0);
      check_eq("bp busy", 32'(o_busy), 32'd1);
      force_active = 1'b0;
      wait_frame("bp");
      step();
      check_eq("bp dv count", 32'(dv_cnt - dv0), 32'(NB));
      cmp_frame("bp");

      // Reset mid-frame at byte 7 while a byte is in flight
      va = rand_vec();
      vb = rand_vec();
      got_q.delete();
      tx_lat = 8;
      send_vec(va);
      wait_bytes(8, "mid");
      rst_n = 1'b0;
      tx_abandon = 1'b1;
      step();
      rst_n = 1'b1;
      check_eq("mid ready", 32'(bus.o_res_ready), 32'd1);
      check_eq("mid busy", 32'(o_busy), 32'd0);
      check_eq("mid dv", 32'(bus.o_tx_dv), 32'd0);
      check_eq("mid overrun cleared", 32'(o_overrun), 32'd0);
      build_frame(vb);
      got_q.delete();
      send_vec(vb);
      wait_frame("mid");
      step();
      cmp_frame("mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
